// File: rtl/joojump_processor_buttons_if.sv
// ---------------------------------------------------------------------------
// JooJumpProcessorButtonsIf
//
// Avalon-MM slave bus bundle for the JooJump push-button input port.
//
//   address     2   register select
//   chipselect  1   slave select
//   write_n     1   active-low write strobe, qualified by chipselect
//   writedata   32  write data
//   readdata    32  read data, zero-latency (combinational from address)
//   irq         1   level interrupt request
//
// master: the interconnect / CPU side.  slave: the button port.
// ---------------------------------------------------------------------------
interface joojump_processor_buttons_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );
endinterface

// File: rtl/joojump_processor_buttons.sv
// ---------------------------------------------------------------------------
// joojump_processor_buttons
//
// Memory-mapped push-button input port for the JooJump Nios II system.
// Each button bit is synchronised (two flops), debounced (must differ from
// the debounced value for DEBOUNCE_CYCLES consecutive cycles before it is
// accepted), and press events (debounced value leaving IDLE_LEVEL) are
// latched into a sticky, write-1-to-clear EDGE_CAPTURE register. irq is
// raised while any captured bit is also enabled in IRQ_MASK.
//
// Register map:
//   0 DATA          RO    debounced value
//   1 IRQ_MASK      RW    per-bit interrupt enable
//   2 reserved            reads 0
//   3 EDGE_CAPTURE  RW1C  sticky press events
//
// Ports:
//   clk_i      system clock, rising edge
//   reset_n_i  asynchronous active-low reset
//   in_port_i  raw asynchronous button inputs
//   bus        Avalon-MM slave bundle (address, chipselect, write_n,
//              writedata, readdata, irq)
// ---------------------------------------------------------------------------
module joojump_processor_buttons #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter bit          IDLE_LEVEL      = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [WIDTH-1:0]           in_port_i,
    joojump_processor_buttons_if.slave bus
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] deb_q;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] debPrev_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;
    logic [WIDTH-1:0] press;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic             wrEn;
    logic             unusedWritedata;

    // Only the low WIDTH bits of writedata reach any register.
    assign unusedWritedata = &{1'b0, bus.writedata};

    // Per-bit debounce: the counter runs only while the synchronised input
    // disagrees with the accepted value; one cycle of agreement resets it.
    // On the DEBOUNCE_CYCLES-th consecutive disagreeing edge the new level
    // is accepted and the counter returns to zero.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // One-cycle press pulse: debounced value just left the idle level.
    // Releases (returning to idle) are deliberately not captured.
    assign press = IDLE_LEVEL ? (debPrev_q & ~deb_q) : (~debPrev_q & deb_q);

    // Register writes. The press set is applied after the W1C clear so a
    // coincident press wins over the clear.
    always_comb begin
        wrEn   = bus.chipselect && !bus.write_n;
        mask_d = mask_q;
        edge_d = edge_q;
        if (wrEn && bus.address == 2'd1) begin
            mask_d = bus.writedata[WIDTH-1:0];
        end
        if (wrEn && bus.address == 2'd3) begin
            edge_d = edge_q & ~bus.writedata[WIDTH-1:0];
        end
        edge_d = edge_d | press;
    end

    // Zero-latency read mux; bits above WIDTH are always zero.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0:    bus.readdata[WIDTH-1:0] = deb_q;
            2'd1:    bus.readdata[WIDTH-1:0] = mask_q;
            2'd3:    bus.readdata[WIDTH-1:0] = edge_q;
            default: bus.readdata = '0;
        endcase
    end

    // Interrupt is built from registers only, never from the bus inputs.
    assign bus.irq = |(edge_q & mask_q);

    // Synchroniser and debounced state restart at the idle level so that
    // leaving reset can never look like a press.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync1_q   <= IDLE_VEC;
            sync2_q   <= IDLE_VEC;
            deb_q     <= IDLE_VEC;
            debPrev_q <= IDLE_VEC;
            mask_q    <= '0;
            edge_q    <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= in_port_i;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            debPrev_q <= deb_q;
            mask_q    <= mask_d;
            edge_q    <= edge_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule
